// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared constants for the push-button / tutorial-switch front end.
//   - Button channel indices (C, L, R, U, D) in btn_raw / btn_pulse order.
//   - Default channel count and default timing constants for a 100 MHz clock.
//   - max_int(): elaboration-time helper used to size the auto-repeat timers.
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int NUM_BTN = 5;

    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_R = 2;
    localparam int BTN_U = 3;
    localparam int BTN_D = 4;

    // Cycle counts at 100 MHz
    localparam int DEBOUNCE_10MS = 1_000_000;
    localparam int REPEAT_500MS  = 50_000_000;
    localparam int REPEAT_100MS  = 10_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One input channel: two-flop synchroniser followed by a counter debouncer.
// A new synchronised level must disagree with the accepted (stable) level for
// DEBOUNCE_CYCLES consecutive cycles before it is accepted; any agreement in
// between restarts the count.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a new level must hold before acceptance (>= 2)
//
// Ports:
//   clk_100mhz  in   system clock
//   reset       in   synchronous, active-high
//   i_raw       in   asynchronous raw pin
//   o_sync      out  synchronised level (second synchroniser flop)
//   o_stable    out  accepted, debounced level (registered)
//   o_accept    out  high in the cycle before o_stable toggles, so the parent
//                    can register edge-derived outputs on the same clock edge
//                    at which o_stable changes
// -----------------------------------------------------------------------------
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
)(
    input  logic clk_100mhz,
    input  logic reset,
    input  logic i_raw,
    output logic o_sync,
    output logic o_stable,
    output logic o_accept
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("debounce_channel: DEBOUNCE_CYCLES must be at least 2");
    end

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_count;
    logic          w_mismatch;

    assign w_mismatch = (r_sync2 != r_stable);
    assign o_accept   = w_mismatch && (r_count == CNT_LAST);
    assign o_sync     = r_sync2;
    assign o_stable   = r_stable;

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_count  <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_mismatch) begin
                r_count <= '0;
            end else if (r_count == CNT_LAST) begin
                r_stable <= r_sync2;
                r_count  <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Front end for the screen/mode FSM: conditions the five raw push-buttons and
// the tutorial-mode slide switch.
//   - Every input is synchronised and debounced by its own debounce_channel.
//   - Buttons produce a one-cycle press pulse and an armed debounced level.
//   - The switch produces a clean debounced level only.
//
// A button channel is disarmed after reset and arms only once its input has
// been observed low (synchronised and accepted both 0). A button held through
// reset therefore gives no pulse until it is released and pressed again.
//
// Optional feature (macro BTN_AUTOREPEAT_EN): channels selected by REPEAT_MASK
// emit extra pulses while held, the first REPEAT_DELAY cycles after the
// initial pulse and then every REPEAT_PERIOD cycles. Without the macro each
// press gives exactly one pulse and the REPEAT_* parameters have no effect.
//
// Parameters:
//   NUM_BTN          number of button channels (C=0, L=1, R=2, U=3, D=4)
//   DEBOUNCE_CYCLES  debounce hold time in cycles (>= 2)
//   REPEAT_DELAY     hold time before the first auto-repeat pulse
//   REPEAT_PERIOD    spacing between auto-repeat pulses
//   REPEAT_MASK      channels eligible for auto-repeat
//
// Ports:
//   clk_100mhz            in   system clock, 100 MHz
//   reset                 in   synchronous, active-high
//   btn_raw               in   raw button pins, active-high
//   sw_tutorial_raw       in   raw tutorial-mode switch pin
//   btn_pulse             out  one-cycle press pulse per channel (registered)
//   btn_level             out  debounced, armed button level (registered)
//   tutorial_mode_active  out  debounced switch level (registered)
// -----------------------------------------------------------------------------
module button_conditioner
    import btn_pkg::*;
#(
    parameter int                   NUM_BTN         = btn_pkg::NUM_BTN,
    parameter int                   DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int                   REPEAT_DELAY    = REPEAT_500MS,
    parameter int                   REPEAT_PERIOD   = REPEAT_100MS,
    parameter logic [NUM_BTN-1:0]   REPEAT_MASK     = NUM_BTN'((1 << BTN_U) | (1 << BTN_D))
)(
    input  logic               clk_100mhz,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               sw_tutorial_raw,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               tutorial_mode_active
);

    logic [NUM_BTN-1:0] w_sync;
    logic [NUM_BTN-1:0] w_stable;
    logic [NUM_BTN-1:0] w_accept;
    logic [NUM_BTN-1:0] w_stable_next;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_level_next;
    logic [NUM_BTN-1:0] w_arm_ok;
    logic [NUM_BTN-1:0] w_rpt_fire;
    logic               w_settled;
    logic               w_sw_stable;
    logic [1:0]         w_sw_unused;

    logic [NUM_BTN-1:0] r_armed;
    logic [NUM_BTN-1:0] r_pulse;
    logic [NUM_BTN-1:0] r_level;
    logic [1:0]         r_settle_cnt;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_100mhz (clk_100mhz),
            .reset      (reset),
            .i_raw      (btn_raw[g]),
            .o_sync     (w_sync[g]),
            .o_stable   (w_stable[g]),
            .o_accept   (w_accept[g])
        );
    end

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_sw (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .i_raw      (sw_tutorial_raw),
        .o_sync     (w_sw_unused[0]),
        .o_stable   (w_sw_stable),
        .o_accept   (w_sw_unused[1])
    );

    // Look one edge ahead so pulse and level register on the very edge at
    // which the debounced level changes, not one cycle later.
    assign w_stable_next = w_stable ^ w_accept;
    assign w_rise        = w_accept & ~w_stable;
    assign w_level_next  = w_stable_next & r_armed;

    // The synchronisers still hold their reset zeros for two cycles after
    // reset; arming waits until they carry real pin samples so that a button
    // held through reset is not mistaken for a released one.
    assign w_settled = (r_settle_cnt == 2'd2);
    assign w_arm_ok  = ~w_stable & ~w_sync & {NUM_BTN{w_settled}};

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            r_settle_cnt <= 2'd0;
            r_armed      <= '0;
            r_pulse      <= '0;
            r_level      <= '0;
        end else begin
            if (!w_settled) begin
                r_settle_cnt <= r_settle_cnt + 2'd1;
            end
            r_armed <= r_armed | w_arm_ok;
            r_pulse <= (w_rise & r_armed) | w_rpt_fire;
            r_level <= w_level_next;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int            RW       = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] FIRE_AT  = RW'(REPEAT_DELAY - 1);
    // After each repeat the timer is rewound so the next match is exactly
    // REPEAT_PERIOD cycles later, reusing a single compare value.
    localparam logic [RW-1:0] RELOAD   = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    if (REPEAT_PERIOD < 2 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_repeat
        $error("button_conditioner: need REPEAT_DELAY >= REPEAT_PERIOD >= 2");
    end

    logic [RW-1:0] r_rpt_timer [NUM_BTN];
    logic [NUM_BTN-1:0] w_rpt_run;

    // Timer runs only while the level is high now and stays high at the next
    // edge; a release about to land suppresses a coincident repeat pulse.
    assign w_rpt_run = REPEAT_MASK & r_level & w_level_next;

    always_comb begin
        w_rpt_fire = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (w_rpt_run[i] && (r_rpt_timer[i] == FIRE_AT)) begin
                w_rpt_fire[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        for (int i = 0; i < NUM_BTN; i++) begin
            if (reset || !w_rpt_run[i]) begin
                r_rpt_timer[i] <= '0;
            end else if (r_rpt_timer[i] == FIRE_AT) begin
                r_rpt_timer[i] <= RELOAD;
            end else begin
                r_rpt_timer[i] <= r_rpt_timer[i] + 1'b1;
            end
        end
    end
`else
    assign w_rpt_fire = '0;
`endif

    assign btn_pulse            = r_pulse;
    assign btn_level            = r_level;
    assign tutorial_mode_active = w_sw_stable;

endmodule
